pcs_tx_framer: RTL and testbench
================================

Name: pcs_tx_framer

Overview:
Parametrised 1000BASE-T PCS transmit framer. It sits between the GMII-side transmit inputs and the symbol mapper/encoder. On each symbol strobe it runs the transmit ordered-set state machine: idle, start-of-stream delimiter (SSD), data, error, carrier extension, CSReset and end-of-stream delimiter (ESD). Each resulting (kind, data) symbol is queued in a FIFO with a valid/ready output handshake, so the downstream mapper can stall without breaking symbol timing.

Parameters:
DATA_W, 8, width of io_txd and io_out_data.
FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.
MIN_IDLE, 2, minimum IDLE symbols between frames (symbol-level IPG); at least 1.
NUM_CSRESET, 2, number of CSRESET symbols emitted before ESD1; at least 1.

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high reset
io_tx_mode  in  1  0 = SEND_Z, 1 = SEND_N
io_symb_timer_done  in  1  symbol strobe; state machine advances only on cycles where this is 1
io_tx_enable  in  1  GMII TX_EN
io_tx_error  in  1  GMII TX_ER
io_txd  in  DATA_W  GMII TXD
io_out_valid  out  1  FIFO head valid
io_out_ready  in  1  downstream accepts head
io_out_kind  out  4  symbol kind at FIFO head
io_out_data  out  DATA_W  data at FIFO head; 0 unless kind = DATA
io_fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy
io_tx_active  out  1  state is in SSD1 through ESD2 or CEXT
io_overflow  out  1  one-cycle pulse when a symbol is dropped
io_frame_abort  out  1  one-cycle pulse when tx_mode=0 ends a frame

Behaviour:
- Kind codes: 0 ZERO, 1 IDLE, 2 SSD1, 3 SSD2, 4 DATA, 5 ERR, 6 CSRESET, 7 ESD1, 8 ESD2, 9 CEXT. Values 10–15 are never emitted.
- Reset values:
  - State = IDLE; idle_cnt = MIN_IDLE, saturating, so a frame may start immediately after reset.
  - FIFO empty: io_out_valid = 0, io_fifo_count = 0, io_out_kind = 0, io_out_data = 0.
  - io_tx_active = 0, io_overflow = 0, io_frame_abort = 0.
- Non-strobe cycles: no state change, no FIFO push. Pops still occur.
- On a strobe, the state machine evaluates its inputs, pushes exactly one symbol for the current decision, and moves to the next state.
- Push latency: a symbol pushed on a strobe at edge N is visible at the FIFO head after edge N if the FIFO was empty, so io_out_valid rises one cycle after the strobe.
- tx_mode = 0 on a strobe, from any state: push ZERO and go to SEND_Z. If the state was SSD1..ESD2 or CEXT, pulse io_frame_abort. SEND_Z stays there and pushes ZERO while tx_mode = 0. When tx_mode returns to 1, push IDLE, go to IDLE and set idle_cnt = 1.
- IDLE:
  - If tx_enable = 1 and idle_cnt >= MIN_IDLE: push SSD1 and go to SSD2. The txd byte is replaced by the delimiter and discarded.
  - Otherwise push IDLE and increment idle_cnt (saturating).
- SSD2: push SSD2 (txd discarded) and go to DATA. If tx_enable = 0 here, go to CSRESET instead (runt frame).
- DATA:
  - tx_enable = 1, tx_error = 0: push DATA with io_txd.
  - tx_enable = 1, tx_error = 1: push ERR with data = 0.
  - tx_enable = 0, tx_error = 1, txd = 8'h0F: push CEXT and go to CEXT.
  - tx_enable = 0 otherwise: push CSRESET, set cs_cnt = 1 and go to CSRESET. If NUM_CSRESET = 1, go directly to ESD1 instead.
- CEXT:
  - If tx_error = 1 and txd = 8'h0F: push CEXT.
  - If tx_error = 1 with any other txd: push ERR and stay in CEXT.
  - If tx_error = 0: push CSRESET and continue as for leaving DATA.
- CSRESET: push CSRESET until NUM_CSRESET CSRESET symbols have been pushed in total, then go to ESD1. tx_enable is ignored.
- ESD1: push ESD1, then go to ESD2.
- ESD2: push ESD2, go to IDLE with idle_cnt = 0. A tx_enable held high waits out MIN_IDLE IDLE symbols and then starts a new frame.
- FIFO push rules:
  - Push when full with io_out_ready = 0: the symbol is dropped, io_overflow pulses, and the state still advances (symbol timing is fixed).
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Pop occurs when io_out_valid & io_out_ready.
- io_tx_active is a registered decode of the state.
- Reset asserted mid-frame: return to the reset values on the next edge. No ESD is emitted and the FIFO is flushed.

Test Plan:
- Nominal frame (MIN_IDLE=2, NUM_CSRESET=2, mode=1, strobe=1 every cycle, ready=1): after reset, tx_enable=1 with txd AA, F0, 0F, CC, then tx_enable=0 → kinds SSD1, SSD2, DATA 0x0F, DATA 0xCC, CSRESET, CSRESET, ESD1, ESD2, IDLE, each one cycle after its strobe. io_tx_active is high for 8 symbols.
- Error and extension: tx_error=1 during DATA → ERR with data 0. Then tx_enable=0, tx_error=1, txd=0x0F for 3 strobes → CEXT x3. Then tx_error=0 → CSRESET, CSRESET, ESD1, ESD2.
- IPG enforcement: tx_enable held at 1 across a frame end → after ESD2 exactly 2 IDLE symbols, then SSD1.
- Backpressure (FIFO_DEPTH=4): ready=0 for 6 strobes → count reaches 4, io_overflow pulses on strobes 5 and 6, and the state sequence is unchanged. With ready=1 and a strobe in the same cycle while full, the count stays at 4 and there is no overflow.
- SEND_Z abort: tx_mode=0 during DATA → ZERO pushed, io_frame_abort pulses once, ZERO repeats. tx_mode=1 → IDLE, IDLE, then SSD1 if tx_enable=1.
- Strobe gating and reset: strobe every 3rd cycle → exactly one push per strobe, no pushes between strobes. Reset asserted mid-DATA → next cycle count=0, io_out_valid=0, then IDLE symbols resume.

Source files
------------

// File: rtl/pcs_tx_framer_if.sv
// Transmit-side bundle for the PCS framer.
//   GMII side : tx_mode, symb_timer_done, tx_enable, tx_error, txd
//   Output    : out_valid/out_ready handshake carrying out_kind/out_data
//   Status    : fifo_count, tx_active, overflow, frame_abort
// slave is the framer's view; master is the view of whatever drives it.
interface pcs_tx_framer_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
);
  logic              tx_mode;
  logic              symb_timer_done;
  logic              tx_enable;
  logic              tx_error;
  logic [DATA_W-1:0] txd;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_kind;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              tx_active;
  logic              overflow;
  logic              frame_abort;

  modport master (
    output tx_mode, symb_timer_done, tx_enable, tx_error, txd, out_ready,
    input  out_valid, out_kind, out_data, fifo_count, tx_active, overflow, frame_abort
  );

  modport slave (
    input  tx_mode, symb_timer_done, tx_enable, tx_error, txd, out_ready,
    output out_valid, out_kind, out_data, fifo_count, tx_active, overflow, frame_abort
  );
endinterface

// File: rtl/pcs_tx_framer.sv
// 1000BASE-T PCS transmit framer.
// On every symbol strobe the ordered-set FSM decides one (kind, data) symbol
// and pushes it into a small FIFO drained by a valid/ready handshake, so the
// mapper may stall without disturbing symbol timing.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : GMII inputs, output handshake and status (see interface)
//
// state     | meaning
// S_IDLE    | between frames, emits IDLE, emits SSD1 when a frame may start
// S_SSD2    | second start delimiter
// S_DATA    | frame body (DATA / ERR)
// S_CEXT    | carrier extension
// S_CSRESET | CSRESET run before the end delimiter
// S_ESD1    | first end delimiter
// S_ESD2    | second end delimiter
// S_SEND_Z  | tx_mode = SEND_Z, emits ZERO
module pcs_tx_framer #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int MIN_IDLE    = 2,
  parameter int NUM_CSRESET = 2
) (
  input  logic           clock,
  input  logic           reset,
  pcs_tx_framer_if.slave bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int IDLE_W = $clog2(MIN_IDLE + 1);
  localparam int CS_W   = $clog2(NUM_CSRESET + 1);
  localparam logic [DATA_W-1:0] CEXT_CODE = DATA_W'(8'h0F);

  localparam logic [3:0] K_ZERO    = 4'd0;
  localparam logic [3:0] K_IDLE    = 4'd1;
  localparam logic [3:0] K_SSD1    = 4'd2;
  localparam logic [3:0] K_SSD2    = 4'd3;
  localparam logic [3:0] K_DATA    = 4'd4;
  localparam logic [3:0] K_ERR     = 4'd5;
  localparam logic [3:0] K_CSRESET = 4'd6;
  localparam logic [3:0] K_ESD1    = 4'd7;
  localparam logic [3:0] K_ESD2    = 4'd8;
  localparam logic [3:0] K_CEXT    = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE, S_SSD2, S_DATA, S_CEXT, S_CSRESET, S_ESD1, S_ESD2, S_SEND_Z
  } state_t;

  state_t            state, state_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  logic [CS_W-1:0]   cs_cnt, cs_nxt, cs_inc;
  logic [3:0]        sym_kind;
  logic [DATA_W-1:0] sym_data;
  logic              abort, end_frame, in_frame, strobe;
  logic              tx_active, overflow, frame_abort;

  logic [3:0]        kind_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              empty, full, push, pop, drop;

  assign strobe   = bus.symb_timer_done;
  assign in_frame = state inside {S_SSD2, S_DATA, S_CEXT, S_CSRESET, S_ESD1, S_ESD2};
  assign cs_inc   = cs_cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    cs_nxt    = cs_cnt;
    sym_kind  = K_IDLE;
    sym_data  = '0;
    abort     = 1'b0;
    end_frame = 1'b0;
    if (!bus.tx_mode) begin
      sym_kind  = K_ZERO;
      state_nxt = S_SEND_Z;
      abort     = in_frame;
    end else begin
      case (state)
        S_SEND_Z: begin
          sym_kind  = K_IDLE;
          state_nxt = S_IDLE;
          idle_nxt  = IDLE_W'(1);
        end
        S_IDLE: begin
          if (bus.tx_enable && idle_cnt >= IDLE_W'(MIN_IDLE)) begin
            sym_kind  = K_SSD1;
            state_nxt = S_SSD2;
          end else begin
            sym_kind = K_IDLE;
            if (idle_cnt < IDLE_W'(MIN_IDLE)) idle_nxt = idle_cnt + 1'b1;
          end
        end
        S_SSD2: begin
          sym_kind = K_SSD2;
          // runt frame: skip the body, still emit the full CSRESET run
          if (bus.tx_enable) begin
            state_nxt = S_DATA;
          end else begin
            state_nxt = S_CSRESET;
            cs_nxt    = '0;
          end
        end
        S_DATA: begin
          if (bus.tx_enable) begin
            if (bus.tx_error) begin
              sym_kind = K_ERR;
            end else begin
              sym_kind = K_DATA;
              sym_data = bus.txd;
            end
          end else if (bus.tx_error && bus.txd == CEXT_CODE) begin
            sym_kind  = K_CEXT;
            state_nxt = S_CEXT;
          end else begin
            end_frame = 1'b1;
          end
        end
        S_CEXT: begin
          if (bus.tx_error) sym_kind = (bus.txd == CEXT_CODE) ? K_CEXT : K_ERR;
          else              end_frame = 1'b1;
        end
        S_CSRESET: begin
          sym_kind = K_CSRESET;
          cs_nxt   = cs_inc;
          if (cs_inc >= CS_W'(NUM_CSRESET)) state_nxt = S_ESD1;
        end
        S_ESD1: begin
          sym_kind  = K_ESD1;
          state_nxt = S_ESD2;
        end
        S_ESD2: begin
          sym_kind  = K_ESD2;
          state_nxt = S_IDLE;
          idle_nxt  = '0;
        end
        default: state_nxt = S_IDLE;
      endcase
      // first CSRESET of the closing run already counts towards NUM_CSRESET
      if (end_frame) begin
        sym_kind  = K_CSRESET;
        cs_nxt    = CS_W'(1);
        state_nxt = (NUM_CSRESET == 1) ? S_ESD1 : S_CSRESET;
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop   = !empty && bus.out_ready;
  // a pop in the same cycle frees the slot, so a push into a full FIFO succeeds
  assign push  = strobe && (!full || pop);
  assign drop  = strobe && full && !pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      idle_cnt    <= IDLE_W'(MIN_IDLE);
      cs_cnt      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_active   <= 1'b0;
      overflow    <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      overflow    <= drop;
      frame_abort <= strobe && abort;
      if (strobe) begin
        state     <= state_nxt;
        idle_cnt  <= idle_nxt;
        cs_cnt    <= cs_nxt;
        // active covers SSD1..ESD2 and CEXT: everything except ZERO/IDLE
        tx_active <= !(sym_kind == K_ZERO || sym_kind == K_IDLE);
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      kind_mem[wr_ptr] <= sym_kind;
      data_mem[wr_ptr] <= sym_data;
    end
  end

  assign bus.out_valid   = !empty;
  assign bus.out_kind    = empty ? K_ZERO : kind_mem[rd_ptr];
  assign bus.out_data    = empty ? '0 : data_mem[rd_ptr];
  assign bus.fifo_count  = count;
  assign bus.tx_active   = tx_active;
  assign bus.overflow    = overflow;
  assign bus.frame_abort = frame_abort;
endmodule

// File: tb/tb_pcs_tx_framer.sv
// Directed bench for pcs_tx_framer with a symbol scoreboard.
// Expected symbols are queued when a strobe is driven and compared when the
// DUT hands them over; a FIFO occupancy model predicts count and overflow.
module tb_pcs_tx_framer;
  localparam int DEPTH = 4;
  localparam logic [3:0] K_ZERO = 4'd0, K_IDLE = 4'd1, K_SSD1 = 4'd2, K_SSD2 = 4'd3,
                         K_DATA = 4'd4, K_ERR = 4'd5, K_CSR = 4'd6, K_ESD1 = 4'd7,
                         K_ESD2 = 4'd8, K_CEXT = 4'd9;

  typedef struct packed {
    logic [3:0] kind;
    logic [7:0] data;
  } sym_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  sym_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   model_cnt = 0;
  logic exp_act = 1'b0;

  pcs_tx_framer_if #(.DATA_W(8), .CNT_W(3)) bus ();

  pcs_tx_framer #(
    .DATA_W(8), .FIFO_DEPTH(DEPTH), .MIN_IDLE(2), .NUM_CSRESET(2)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, compare the handed-over symbol, then check status
  task automatic step(input logic stb, input logic en, input logic er, input logic [7:0] d,
                      input logic [3:0] k, input logic [7:0] kd, input logic abt);
    logic pop, drop;
    bus.symb_timer_done = stb;
    bus.tx_enable       = en;
    bus.tx_error        = er;
    bus.txd             = d;
    #1;
    chk("valid", 32'(bus.out_valid), 32'(model_cnt != 0));
    pop = (model_cnt != 0) && bus.out_ready;
    if (pop) begin
      chk("kind", 32'(bus.out_kind), 32'(q[0].kind));
      chk("data", 32'(bus.out_data), 32'(q[0].data));
      void'(q.pop_front());
    end
    drop = stb && (model_cnt == DEPTH) && !pop;
    if (stb && !drop) q.push_back({k, kd});
    model_cnt = model_cnt + ((stb && !drop) ? 1 : 0) - (pop ? 1 : 0);
    if (stb) exp_act = (k != K_ZERO) && (k != K_IDLE);
    @(posedge clk);
    #1;
    chk("count", 32'(bus.fifo_count), 32'(model_cnt));
    chk("overflow", 32'(bus.overflow), 32'(drop));
    chk("active", 32'(bus.tx_active), 32'(exp_act));
    chk("abort", 32'(bus.frame_abort), 32'(abt));
  endtask

  task automatic s(input logic en, input logic er, input logic [7:0] d,
                   input logic [3:0] k, input logic [7:0] kd);
    step(1'b1, en, er, d, k, kd, 1'b0);
  endtask

  task automatic n();
    step(1'b0, 1'b0, 1'b0, 8'h00, K_ZERO, 8'h00, 1'b0);
  endtask

  task automatic chk_reset_state();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_kind", 32'(bus.out_kind), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_active", 32'(bus.tx_active), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_abort", 32'(bus.frame_abort), 32'd0);
  endtask

  initial begin
    bus.tx_mode         = 1'b1;
    bus.symb_timer_done = 1'b0;
    bus.tx_enable       = 1'b0;
    bus.tx_error        = 1'b0;
    bus.txd             = 8'h00;
    bus.out_ready       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0;

    // nominal frame
    s(0, 0, 8'h00, K_IDLE, 8'h00);
    s(0, 0, 8'h00, K_IDLE, 8'h00);
    s(1, 0, 8'hAA, K_SSD1, 8'h00);
    s(1, 0, 8'hF0, K_SSD2, 8'h00);
    s(1, 0, 8'h0F, K_DATA, 8'h0F);
    s(1, 0, 8'hCC, K_DATA, 8'hCC);
    s(0, 0, 8'h00, K_CSR,  8'h00);
    s(0, 0, 8'h00, K_CSR,  8'h00);
    s(0, 0, 8'h00, K_ESD1, 8'h00);
    s(0, 0, 8'h00, K_ESD2, 8'h00);
    s(0, 0, 8'h00, K_IDLE, 8'h00);

    // error and carrier extension, then IPG with tx_enable held high
    s(0, 0, 8'h00, K_IDLE, 8'h00);
    s(1, 0, 8'hA1, K_SSD1, 8'h00);
    s(1, 0, 8'hA2, K_SSD2, 8'h00);
    s(1, 0, 8'h11, K_DATA, 8'h11);
    s(1, 1, 8'h12, K_ERR,  8'h00);
    s(0, 1, 8'h0F, K_CEXT, 8'h00);
    s(0, 1, 8'h0F, K_CEXT, 8'h00);
    s(0, 1, 8'h0F, K_CEXT, 8'h00);
    s(0, 1, 8'h55, K_ERR,  8'h00);
    s(0, 0, 8'h00, K_CSR,  8'h00);
    s(0, 0, 8'h00, K_CSR,  8'h00);
    s(1, 0, 8'h00, K_ESD1, 8'h00);
    s(1, 0, 8'h00, K_ESD2, 8'h00);
    s(1, 0, 8'h00, K_IDLE, 8'h00);
    s(1, 0, 8'h00, K_IDLE, 8'h00);
    s(1, 0, 8'hE1, K_SSD1, 8'h00);
    s(1, 0, 8'hE2, K_SSD2, 8'h00);
    s(1, 0, 8'h5A, K_DATA, 8'h5A);

    // backpressure: drain, then six strobes with ready low
    n();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) s(1, 0, 8'(i), K_DATA, 8'(i));
    bus.out_ready = 1'b1;
    s(1, 0, 8'h07, K_DATA, 8'h07);
    repeat (4) n();

    // SEND_Z abort mid-frame and recovery
    bus.tx_mode = 1'b0;
    step(1'b1, 1'b1, 1'b0, 8'h00, K_ZERO, 8'h00, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h00, K_ZERO, 8'h00, 1'b0);
    bus.tx_mode = 1'b1;
    s(1, 0, 8'h00, K_IDLE, 8'h00);
    s(1, 0, 8'h00, K_IDLE, 8'h00);
    s(1, 0, 8'hAB, K_SSD1, 8'h00);
    s(1, 0, 8'hCD, K_SSD2, 8'h00);
    s(1, 0, 8'h77, K_DATA, 8'h77);

    // strobe every third cycle
    s(1, 0, 8'h81, K_DATA, 8'h81);
    n();
    n();
    s(1, 0, 8'h82, K_DATA, 8'h82);
    n();

    // reset mid-DATA flushes everything
    bus.symb_timer_done = 1'b1;
    bus.tx_enable       = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_state();
    q.delete();
    model_cnt = 0;
    exp_act   = 1'b0;
    rst = 1'b0;

    // frame may start at once after reset; runt frame at SSD2
    s(0, 0, 8'h00, K_IDLE, 8'h00);
    s(1, 0, 8'h11, K_SSD1, 8'h00);
    s(0, 0, 8'h22, K_SSD2, 8'h00);
    s(0, 0, 8'h00, K_CSR,  8'h00);
    s(0, 0, 8'h00, K_CSR,  8'h00);
    s(0, 0, 8'h00, K_ESD1, 8'h00);
    s(0, 0, 8'h00, K_ESD2, 8'h00);
    s(0, 0, 8'h00, K_IDLE, 8'h00);
    n();
    n();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
